neuron_timestep_sequencer: RTL and testbench

Drives the LIF `potential_adder_10` datapath once per neuron per timestep. It holds the membrane potential of every neuron and applies the decay factor. It presents `input_weight` and `decayed_potential` to the adder, then captures `final_potential` and `spike` back into state. It is the initiator side of the adder interface: it issues the adder's `set` initialisation and `clear` idle hold, and reports spikes and timestep completion to the NoC layer.

---
 rtl/neuron_timestep_sequencer.sv | 173 +++++++++++++++++
 tb/tb_neuron_timestep_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_timestep_sequencer.sv
// neuron_timestep_sequencer
// Walks every neuron once per timestep through the external LIF potential adder.
// The membrane potential of each neuron is held here. Each stored potential is
// decayed by DECAY and sent to the adder together with the incoming weight. The
// adder result and spike are then written back.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   start                      begin a timestep (sampled in IDLE)
//   weight_valid/data/ready    per-neuron weight handshake
//   cur_neuron                 neuron currently being processed
//   adder_input_weight         registered adder operand
//   adder_decayed_potential    registered adder operand
//   adder_set, adder_clear     adder init strobe / idle hold
//   adder_final_potential      adder result
//   adder_spike                adder spike
//   spike_valid, spike_neuron  one-cycle spike event to the NoC
//   timestep_done              one-cycle pulse after the last write-back
//   busy                       high outside IDLE
//   decay_err                  sticky decay-multiplier exception flag
//   rd_addr, rd_data           combinational debug read of a stored potential
//
// state   | meaning
// --------+----------------------------------------------------------
// INIT    | one adder_set cycle after reset release, then IDLE
// IDLE    | adder held in clear, wait for start
// WAIT_W  | weight_ready high, wait for weight_valid
// ISSUE   | operands held so the adder settles
// CAPTURE | write adder result back, schedule spike / timestep_done

module neuron_timestep_sequencer #(
    parameter int          NUM_NEURONS = 8,
    parameter int          IDX_W       = 3,
    parameter logic [31:0] DECAY       = 32'h3F000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             weight_valid,
    input  logic [31:0]      weight_data,
    output logic             weight_ready,
    output logic [IDX_W-1:0] cur_neuron,
    output logic [31:0]      adder_input_weight,
    output logic [31:0]      adder_decayed_potential,
    output logic             adder_set,
    output logic             adder_clear,
    input  logic [31:0]      adder_final_potential,
    input  logic             adder_spike,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_neuron,
    output logic             timestep_done,
    output logic             busy,
    output logic             decay_err,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data
);

    typedef enum logic [2:0] {INIT, IDLE, WAIT_W, ISSUE, CAPTURE} state_t;

    localparam logic [31:0] DEC = DECAY;

    state_t      state, state_nx;
    logic        armed;
    logic        accept, capture, last;
    logic [31:0] potential [NUM_NEURONS];

    // Decay multiplier: potential[cur_neuron] x DECAY. Subnormal inputs are
    // treated as zero and the mantissa is truncated.
    logic [31:0]       pot_cur;
    logic [47:0]       prod;
    logic signed [9:0] exp_r;
    logic [22:0]       man_r;
    logic [31:0]       decayed;
    logic              mul_err;

    assign pot_cur = potential[cur_neuron];
    assign last    = (cur_neuron == IDX_W'(NUM_NEURONS - 1));

    always_comb begin
        prod    = {24'b0, 1'b1, pot_cur[22:0]} * {24'b0, 1'b1, DEC[22:0]};
        exp_r   = 10'(pot_cur[30:23]) + 10'(DEC[30:23]) - 10'd127 + {9'b0, prod[47]};
        man_r   = prod[47] ? prod[46:24] : prod[45:23];
        decayed = 32'h0;
        mul_err = 1'b0;
        if (pot_cur[30:23] == 8'hFF || DEC[30:23] == 8'hFF) begin
            mul_err = 1'b1;
        end else if (pot_cur[30:23] == 8'h00 || DEC[30:23] == 8'h00) begin
            decayed = 32'h0;
        end else if (exp_r >= 10'sd255 || exp_r <= 10'sd0) begin
            mul_err = 1'b1;
        end else begin
            decayed = {pot_cur[31] ^ DEC[31], exp_r[7:0], man_r};
        end
    end

    // INIT is held for one extra cycle while "armed" is low. The reset cycle
    // therefore shows no adder_set, and adder_set rises on the first edge after release.
    always_comb begin
        state_nx     = state;
        weight_ready = 1'b0;
        adder_set    = 1'b0;
        adder_clear  = 1'b0;
        busy         = 1'b1;
        accept       = 1'b0;
        capture      = 1'b0;
        case (state)
            INIT: begin
                adder_set = armed;
                busy      = armed;
                if (armed) state_nx = IDLE;
            end
            IDLE: begin
                adder_clear = 1'b1;
                busy        = 1'b0;
                if (start) state_nx = WAIT_W;
            end
            WAIT_W: begin
                weight_ready = 1'b1;
                if (weight_valid) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = CAPTURE;
            CAPTURE: begin
                capture  = 1'b1;
                state_nx = last ? IDLE : WAIT_W;
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= INIT;
            armed                   <= 1'b0;
            cur_neuron              <= '0;
            adder_input_weight      <= 32'h0;
            adder_decayed_potential <= 32'h0;
            spike_valid             <= 1'b0;
            spike_neuron            <= '0;
            timestep_done           <= 1'b0;
            decay_err               <= 1'b0;
        end else begin
            state         <= state_nx;
            armed         <= 1'b1;
            spike_valid   <= capture & adder_spike;
            timestep_done <= capture & last;
            if (state == IDLE && start) cur_neuron <= '0;
            else if (capture && !last)  cur_neuron <= cur_neuron + 1'b1;
            if (capture) spike_neuron <= cur_neuron;
            if (accept) begin
                adder_input_weight      <= weight_data;
                adder_decayed_potential <= decayed;
                decay_err               <= decay_err | mul_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) potential[i] <= 32'h0;
        end else if (capture) begin
            potential[cur_neuron] <= adder_final_potential;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        if ({{(32-IDX_W){1'b0}}, rd_addr} < NUM_NEURONS) rd_data = potential[rd_addr];
    end

endmodule

// File: tb/tb_neuron_timestep_sequencer.sv
`timescale 1ns/100ps
module tb_neuron_timestep_sequencer;

    localparam int          N     = 8;
    localparam int          IW    = 3;
    localparam logic [31:0] DECAY = 32'h3F000000;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, weight_valid = 1'b0;
    logic [31:0]   weight_data = 32'h0;
    logic          weight_ready, adder_set, adder_clear, adder_spike;
    logic          spike_valid, timestep_done, busy, decay_err;
    logic [IW-1:0] cur_neuron, spike_neuron, rd_addr = '0;
    logic [31:0]   adder_input_weight, adder_decayed_potential, adder_final_potential, rd_data;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int spk_cnt = 0, done_cnt = 0, exp_done = 0;
    logic [31:0] w [N];
    logic [31:0] pot [N];
    bit model_err = 0;

    neuron_timestep_sequencer #(.NUM_NEURONS(N), .IDX_W(IW), .DECAY(DECAY)) dut (
        .clk(clk), .reset(reset), .start(start),
        .weight_valid(weight_valid), .weight_data(weight_data), .weight_ready(weight_ready),
        .cur_neuron(cur_neuron),
        .adder_input_weight(adder_input_weight), .adder_decayed_potential(adder_decayed_potential),
        .adder_set(adder_set), .adder_clear(adder_clear),
        .adder_final_potential(adder_final_potential), .adder_spike(adder_spike),
        .spike_valid(spike_valid), .spike_neuron(spike_neuron),
        .timestep_done(timestep_done), .busy(busy), .decay_err(decay_err),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic real to_real(logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        if (e == 255) m = 1.0e39;
        else m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] from_real(real r);
        real  a;
        int   e, f;
        logic s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        if (a >= 3.4028235e38) return {s, 8'hFF, 23'h0};
        if (a < 1.1754944e-38) return 32'h0;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        f = int'((a - 1.0) * 8388608.0);
        if (f == 8388608) begin f = 0; e++; end
        return {s, 8'(e + 127), f[22:0]};
    endfunction

    // Stand-in for the LIF adder: sum, and on exceeding 67.89 subtract it and spike.
    function automatic logic [32:0] adder_model(logic [31:0] a, logic [31:0] b);
        real s, thr;
        thr = to_real(from_real(67.89));
        s   = to_real(a) + to_real(b);
        if (s > thr) return {1'b1, from_real(s - thr)};
        return {1'b0, from_real(s)};
    endfunction

    function automatic logic [31:0] model_decay(logic [31:0] p, output bit err);
        real r, m;
        err = 0;
        if (p[30:23] == 8'hFF) begin err = 1; return 32'h0; end
        r = to_real(p) * to_real(DECAY);
        if (r == 0.0) return 32'h0;
        m = (r < 0.0) ? -r : r;
        if (m < 1.1754944e-38 || m >= 3.4028235e38) begin err = 1; return 32'h0; end
        return from_real(r);
    endfunction

    always_comb {adder_spike, adder_final_potential} = adder_model(adder_input_weight, adder_decayed_potential);

    always @(negedge clk) begin
        if (!reset && spike_valid)   spk_cnt++;
        if (!reset && timestep_done) done_cnt++;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rnd_weight();
        return from_real((real'($urandom_range(0, 20000)) - 10000.0) / 100.0);
    endfunction

    task automatic reset_seq();
        reset = 1'b1;
        #1;
        chk("rst_set", 32'(adder_set), 0);
        chk("rst_clear", 32'(adder_clear), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(weight_ready), 0);
        chk("rst_op_w", adder_input_weight, 0);
        chk("rst_op_d", adder_decayed_potential, 0);
        chk("rst_cur", 32'(cur_neuron), 0);
        chk("rst_spk", {31'b0, spike_valid} | 32'(spike_neuron), 0);
        chk("rst_done", 32'(timestep_done), 0);
        chk("rst_err", 32'(decay_err), 0);
        for (int i = 0; i < N; i++) begin
            rd_addr = IW'(i);
            #1;
            chk("rst_pot", rd_data, 0);
            pot[i] = 32'h0;
        end
        model_err = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("init_set", 32'(adder_set), 1);
        chk("init_busy", 32'(busy), 1);
        tick();
        chk("idle_set", 32'(adder_set), 0);
        chk("idle_clear", 32'(adder_clear), 1);
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50 && !(adder_clear && !busy); k++) tick();
        if (k == 50) chk("idle_timeout", 0, 1);
    endtask

    // One timestep driven from w[]; the model pot[] is updated alongside.
    task automatic run_ts(int stall_n, int stall_len, bit poke_start, int abort_n);
        int          t0;
        bit          e, sp;
        logic [31:0] dec, np;
        logic [32:0] am;
        wait_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        for (int n = 0; n < N; n++) begin
            if (n == stall_n) begin
                for (int s = 0; s < stall_len; s++) begin
                    weight_valid = 1'b0;
                    weight_data  = $urandom;
                    chk("stall_ready", 32'(weight_ready), 1);
                    chk("stall_cur", 32'(cur_neuron), n);
                    tick();
                end
            end
            chk("ready", 32'(weight_ready), 1);
            chk("cur", 32'(cur_neuron), n);
            weight_valid = 1'b1;
            weight_data  = w[n];
            tick();
            weight_valid = 1'($urandom_range(0, 1));
            weight_data  = $urandom;
            dec = model_decay(pot[n], e);
            if (e) model_err = 1;
            am = adder_model(w[n], dec);
            sp = am[32];
            np = am[31:0];
            chk("op_weight", adder_input_weight, w[n]);
            chk("op_decayed", adder_decayed_potential, dec);
            chk("issue_ready", 32'(weight_ready), 0);
            chk("decay_err", 32'(decay_err), 32'(model_err));
            if (n == abort_n) begin
                weight_valid = 1'b0;
                reset_seq();
                return;
            end
            start   = poke_start;
            rd_addr = IW'(n);
            tick();
            start = 1'b0;
            tick();
            pot[n] = np;
            chk("spike_valid", 32'(spike_valid), 32'(sp));
            if (sp) chk("spike_neuron", 32'(spike_neuron), n);
            chk("pot_wb", rd_data, np);
            chk("done", 32'(timestep_done), 32'(n == N - 1));
            if (n == N - 1) begin
                chk("done_idle", 32'(adder_clear), 1);
                chk("ts_len", 32'(cyc - t0), 32'(3 * N + stall_len));
            end
        end
        weight_valid = 1'b0;
        exp_done++;
        tick();
        chk("done_once", 32'(timestep_done), 0);
    endtask

    initial begin
        int s0, d0;
        #2;
        reset_seq();

        // Timestep 1 and 2: all weights 50.0
        for (int i = 0; i < N; i++) w[i] = 32'h42480000;
        s0 = spk_cnt;
        run_ts(-1, 0, 0, -1);
        chk("ts1_spikes", 32'(spk_cnt - s0), 0);
        for (int i = 0; i < N; i++) begin
            rd_addr = IW'(i);
            #1;
            chk("ts1_pot", rd_data, 32'h42480000);
        end
        s0 = spk_cnt;
        run_ts(-1, 0, 0, -1);
        chk("ts2_spikes", 32'(spk_cnt - s0), N);
        for (int i = 0; i < N; i++) begin
            int d;
            rd_addr = IW'(i);
            #1;
            d = int'(rd_data) - int'(32'h40E3851F);
            chk("ts2_pot_ulp", 32'(d >= -1 && d <= 1), 1);
        end

        // Stall at neuron 3 for 5 cycles, start poked while busy
        for (int i = 0; i < N; i++) w[i] = rnd_weight();
        d0 = done_cnt;
        run_ts(3, 5, 1, -1);
        tick();
        chk("poke_ignored", 32'(done_cnt - d0), 1);
        chk("poke_idle", 32'(busy), 0);

        // Randomized timesteps with random stalls
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) w[i] = rnd_weight();
            run_ts($urandom_range(0, N - 1), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
        end

        // Reset during ISSUE of neuron 4
        for (int i = 0; i < N; i++) w[i] = rnd_weight();
        run_ts(-1, 0, 0, 4);
        repeat (10) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(exp_done));

        // +inf weight, then decay exception on the following timestep
        for (int i = 0; i < N; i++) w[i] = rnd_weight();
        w[2] = 32'h7F800000;
        run_ts(-1, 0, 0, -1);
        rd_addr = IW'(2);
        #1;
        chk("inf_pot", rd_data, 32'h7F800000);
        chk("err_before", 32'(decay_err), 0);
        for (int i = 0; i < N; i++) w[i] = rnd_weight();
        run_ts(-1, 0, 0, -1);
        chk("err_set", 32'(decay_err), 1);
        for (int i = 0; i < N; i++) w[i] = rnd_weight();
        run_ts($urandom_range(0, N - 1), 2, 0, -1);
        chk("err_sticky", 32'(decay_err), 1);
        @(posedge clk);
        #1;
        reset_seq();

        chk("done_total", 32'(done_cnt), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
